axil_wr_master: RTL and testbench

AXIL_WR_MASTER -- requirements
Module: axil_wr_master

---
 rtl/axil_pkg.sv | 31 +++
 rtl/axil_cmd_fifo.sv | 55 +++++
 rtl/axil_wr_master.sv | 183 ++++++++++++++++++
 tb/tb_axil_wr_master.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared types for the AXI4-Lite write master: response codes, FSM states, command payload.
package axil_pkg;

  localparam int unsigned AXIL_ADDR_W = 16;
  localparam int unsigned AXIL_DATA_W = 32;
  localparam int unsigned AXIL_STRB_W = AXIL_DATA_W / 8;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    WAIT_B = 2'd2
  } state_e;

  typedef struct packed {
    logic [AXIL_ADDR_W-1:0] addr;
    logic [AXIL_DATA_W-1:0] data;
    logic [AXIL_STRB_W-1:0] strb;
  } axil_wr_cmd_t;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/axil_cmd_fifo.sv
// Synchronous command FIFO with registered occupancy; no write-through bypass.
module axil_cmd_fifo
  import axil_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter type T = axil_wr_cmd_t
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  T     wdata_i,
  input  logic pop_i,
  output T     rdata_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q;
  logic [PTR_W-1:0] rptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_W'(1);
      if (do_pop)  rptr_q <= rptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/axil_wr_master.sv
// AXI4-Lite write master: queued commands issued one at a time over AW/W, completed on B.
// Optional watchdog on SEND/WAIT_B enabled by defining AXIL_WR_MASTER_TIMEOUT_EN.
module axil_wr_master
  import axil_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic                axi_aclk,
  input  logic                axi_areset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_data,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic [ADDR_W-1:0]   axi_awaddr,
  output logic [2:0]          axi_awprot,
  output logic                axi_awvalid,
  input  logic                axi_awready,
  output logic [DATA_W-1:0]   axi_wdata,
  output logic [DATA_W/8-1:0] axi_wstrb,
  output logic                axi_wvalid,
  input  logic                axi_wready,
  input  logic [1:0]          axi_bresp,
  input  logic                axi_bvalid,
  output logic                axi_bready,
  output logic                busy,
  output logic                err,
  output logic                timeout,
  input  logic                err_clr,
  output logic [15:0]         wr_count
);

  localparam int unsigned STRB_W = DATA_W / 8;

  if (!is_pow2(FIFO_DEPTH) || FIFO_DEPTH < 2 || TIMEOUT_CYC < 2) begin : g_param_check
    $error("axil_wr_master: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYC >= 2");
  end

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } cmd_t;

  state_e            state_q;
  logic              awvalid_q;
  logic              wvalid_q;
  logic              bready_q;
  logic [ADDR_W-1:0] awaddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [15:0]       wr_count_q;
  logic              err_q;

  cmd_t push_cmd;
  cmd_t head_cmd;
  logic fifo_full;
  logic fifo_empty;
  logic fifo_pop;
  logic aw_done;
  logic w_done;
  logic b_hs;
  logic err_set;
  logic tmo_fire;

  assign push_cmd = '{addr: cmd_addr, data: cmd_data, strb: cmd_strb};
  assign fifo_pop = (state_q == IDLE) && !fifo_empty;

  axil_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (cmd_t)
  ) u_fifo (
    .clk_i   (axi_aclk),
    .rst_i   (axi_areset),
    .push_i  (cmd_valid),
    .wdata_i (push_cmd),
    .pop_i   (fifo_pop),
    .rdata_o (head_cmd),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A channel counts as done once its valid has dropped or is accepted this cycle.
  assign aw_done = !awvalid_q || axi_awready;
  assign w_done  = !wvalid_q || axi_wready;
  assign b_hs    = (state_q == WAIT_B) && axi_bvalid && !tmo_fire;
  assign err_set = b_hs && (resp_e'(axi_bresp) != OKAY);

`ifdef AXIL_WR_MASTER_TIMEOUT_EN
  localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [TCNT_W-1:0] tcnt_q;
  logic              timeout_q;

  assign tmo_fire = (state_q != IDLE) && (tcnt_q == TCNT_W'(TIMEOUT_CYC - 1));
  assign timeout  = timeout_q;

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == IDLE || tmo_fire) tcnt_q <= '0;
      else                             tcnt_q <= tcnt_q + TCNT_W'(1);
      if (tmo_fire)     timeout_q <= 1'b1;
      else if (err_clr) timeout_q <= 1'b0;
    end
  end
`else
  assign tmo_fire = 1'b0;
  assign timeout  = 1'b0;
`endif

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state_q    <= IDLE;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wr_count_q <= '0;
    end else if (tmo_fire) begin
      state_q   <= IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            awaddr_q  <= head_cmd.addr;
            wdata_q   <= head_cmd.data;
            wstrb_q   <= head_cmd.strb;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state_q   <= SEND;
          end
        end
        SEND: begin
          if (awvalid_q && axi_awready) awvalid_q <= 1'b0;
          if (wvalid_q && axi_wready)   wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state_q  <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (b_hs) begin
            bready_q   <= 1'b0;
            wr_count_q <= wr_count_q + 16'd1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Sticky error: a new error in the same cycle as err_clr takes precedence.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset)   err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
    else if (err_clr) err_q <= 1'b0;
  end

  assign cmd_ready   = !fifo_full;
  assign busy        = !fifo_empty || (state_q != IDLE);
  assign axi_awaddr  = awaddr_q;
  assign axi_awprot  = 3'b000;
  assign axi_awvalid = awvalid_q;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = wstrb_q;
  assign axi_wvalid  = wvalid_q;
  assign axi_bready  = bready_q;
  assign err         = err_q;
  assign wr_count    = wr_count_q;

endmodule

// File: tb/tb_axil_wr_master.sv
// Directed bench for axil_wr_master: vector table of single writes plus multi-cycle sequences.
`timescale 1ns/1ps
module tb_axil_wr_master;
  import axil_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic [3:0]  cmd_strb = '0;
  logic [15:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0;
  logic        bready;
  logic        busy;
  logic        err;
  logic        timeout;
  logic        err_clr = 1'b0;
  logic [15:0] wr_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    int          b_dly;
    logic [1:0]  bresp;
    logic        clr_before;
    logic        clr_with_b;
    logic        exp_err;
    logic [15:0] exp_cnt;
  } vec_t;

  axil_wr_master #(
    .ADDR_W(16), .DATA_W(32), .FIFO_DEPTH(8), .TIMEOUT_CYC(256)
  ) dut (
    .axi_aclk(clk), .axi_areset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_strb(cmd_strb),
    .axi_awaddr(awaddr), .axi_awprot(awprot), .axi_awvalid(awvalid), .axi_awready(awready),
    .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wvalid(wvalid), .axi_wready(wready),
    .axi_bresp(bresp), .axi_bvalid(bvalid), .axi_bready(bready),
    .busy(busy), .err(err), .timeout(timeout), .err_clr(err_clr), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_strb  = s;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Acts as the slave for one write and checks payload, handshake count and completion.
  task automatic serve(input vec_t v, input string tag);
    int c;
    int aw_n;
    int w_n;
    c = 0;
    while (!(awvalid || wvalid) && c < 50) begin
      tick();
      c++;
    end
    if (c >= 50) fail_bound($sformatf("%s.valid_wait", tag));
    c = 0; aw_n = 0; w_n = 0;
    while ((aw_n == 0 || w_n == 0) && c < 100) begin
      awready = (c >= v.aw_dly);
      wready  = (c >= v.w_dly);
      if (awvalid && awready) begin
        aw_n++;
        chk($sformatf("%s.awaddr", tag), 32'(awaddr), 32'(v.addr));
      end
      if (wvalid && wready) begin
        w_n++;
        chk($sformatf("%s.wdata", tag), wdata, v.data);
        chk($sformatf("%s.wstrb", tag), 32'(wstrb), 32'(v.strb));
      end
      tick();
      c++;
    end
    awready = 1'b0;
    wready  = 1'b0;
    if (aw_n == 0 || w_n == 0) fail_bound($sformatf("%s.handshake", tag));
    chk($sformatf("%s.awvalid_low", tag), 32'(awvalid), 32'd0);
    chk($sformatf("%s.wvalid_low", tag), 32'(wvalid), 32'd0);
    chk($sformatf("%s.bready_high", tag), 32'(bready), 32'd1);
    for (int i = 0; i < v.b_dly; i++) tick();
    bvalid  = 1'b1;
    bresp   = v.bresp;
    err_clr = v.clr_with_b;
    tick();
    bvalid  = 1'b0;
    bresp   = 2'b00;
    err_clr = 1'b0;
    chk($sformatf("%s.bready_low", tag), 32'(bready), 32'd0);
    chk($sformatf("%s.wr_count", tag), 32'(wr_count), 32'(v.exp_cnt));
    chk($sformatf("%s.err", tag), 32'(err), 32'(v.exp_err));
  endtask

  initial begin
    vec_t tbl[6];
    vec_t v;
    int   n;

    tbl[0] = '{16'h0100, 32'hDEADBEEF, 4'hF, 1, 0, 0, OKAY,   1'b0, 1'b0, 1'b0, 16'd3};
    tbl[1] = '{16'h0104, 32'h12345678, 4'h3, 0, 2, 2, SLVERR, 1'b0, 1'b0, 1'b1, 16'd4};
    tbl[2] = '{16'h0108, 32'hA5A5A5A5, 4'hC, 2, 2, 0, OKAY,   1'b0, 1'b0, 1'b1, 16'd5};
    tbl[3] = '{16'h010C, 32'h00000000, 4'h1, 3, 1, 1, OKAY,   1'b1, 1'b0, 1'b0, 16'd6};
    tbl[4] = '{16'hFFFC, 32'hFFFFFFFF, 4'hF, 0, 0, 3, DECERR, 1'b0, 1'b0, 1'b1, 16'd7};
    tbl[5] = '{16'h0010, 32'h000055AA, 4'h8, 0, 4, 0, EXOKAY, 1'b1, 1'b1, 1'b1, 16'd8};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst.awvalid", 32'(awvalid), 32'd0);
    chk("rst.wvalid", 32'(wvalid), 32'd0);
    chk("rst.bready", 32'(bready), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    chk("rst.timeout", 32'(timeout), 32'd0);
    chk("rst.wr_count", 32'(wr_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("rst.cmd_ready", 32'(cmd_ready), 32'd1);

    // Single write, push-to-valid latency of two cycles
    push(16'h2000, 32'h00000FFF, 4'hF);
    chk("lat.awvalid_t1", 32'(awvalid), 32'd0);
    chk("lat.busy_t1", 32'(busy), 32'd1);
    tick();
    chk("lat.awvalid_t2", 32'(awvalid), 32'd1);
    chk("lat.wvalid_t2", 32'(wvalid), 32'd1);
    chk("lat.awaddr_t2", 32'(awaddr), 32'h2000);
    chk("lat.awprot", 32'(awprot), 32'd0);
    v = '{16'h2000, 32'h00000FFF, 4'hF, 0, 0, 0, OKAY, 1'b0, 1'b0, 1'b0, 16'd1};
    serve(v, "single");

    // awready at cycle 0, wready at cycle 3
    push(16'h3000, 32'hCAFEF00D, 4'h6);
    tick();
    awready = 1'b1;
    tick();
    awready = 1'b0;
    chk("split.awvalid_c1", 32'(awvalid), 32'd0);
    chk("split.wvalid_c1", 32'(wvalid), 32'd1);
    tick();
    chk("split.wvalid_c2", 32'(wvalid), 32'd1);
    chk("split.wdata_c2", wdata, 32'hCAFEF00D);
    chk("split.bready_c2", 32'(bready), 32'd0);
    tick();
    wready = 1'b1;
    tick();
    wready = 1'b0;
    chk("split.wvalid_c4", 32'(wvalid), 32'd0);
    chk("split.bready_c4", 32'(bready), 32'd1);
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    chk("split.bready_done", 32'(bready), 32'd0);
    chk("split.wr_count", 32'(wr_count), 32'd2);

    // Vector table
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].clr_before) begin
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk($sformatf("vec%0d.err_cleared", i), 32'(err), 32'd0);
      end
      push(tbl[i].addr, tbl[i].data, tbl[i].strb);
      serve(tbl[i], $sformatf("vec%0d", i));
    end

    // bvalid while idle is ignored
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("idle_b.err_cleared", 32'(err), 32'd0);
    bvalid = 1'b1;
    bresp  = SLVERR;
    tick();
    bvalid = 1'b0;
    bresp  = 2'b00;
    tick();
    chk("idle_b.wr_count", 32'(wr_count), 32'd8);
    chk("idle_b.err", 32'(err), 32'd0);
    chk("idle_b.busy", 32'(busy), 32'd0);

    // Stalled slave: nine pushes fill the FIFO, full refuses a push even during a pop
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("fill%0d.cmd_ready", i), 32'(cmd_ready), 32'd1);
      push(16'(4 * i), 32'h1000 + 32'(i), 4'hF);
    end
    chk("fill.cmd_ready_full", 32'(cmd_ready), 32'd0);
    chk("fill.busy", 32'(busy), 32'd1);
    cmd_valid = 1'b1;
    cmd_addr  = 16'hBAD0;
    cmd_data  = 32'hBAD0BAD0;
    cmd_strb  = 4'hF;
    v = '{16'h0000, 32'h1000, 4'hF, 0, 0, 0, OKAY, 1'b0, 1'b0, 1'b0, 16'd9};
    serve(v, "drain0");
    chk("drain.ready_at_pop", 32'(cmd_ready), 32'd0);
    tick();
    cmd_valid = 1'b0;
    chk("drain.ready_after_pop", 32'(cmd_ready), 32'd1);
    for (int i = 1; i < 9; i++) begin
      v = '{16'(4 * i), 32'h1000 + 32'(i), 4'hF, i % 3, (i + 1) % 2, 0, OKAY,
            1'b0, 1'b0, 1'b0, 16'(9 + i)};
      serve(v, $sformatf("drain%0d", i));
    end
    repeat (4) tick();
    chk("drain.busy_end", 32'(busy), 32'd0);
    chk("drain.no_extra", 32'(awvalid), 32'd0);
    chk("drain.wr_count", 32'(wr_count), 32'd17);

`ifdef AXIL_WR_MASTER_TIMEOUT_EN
    // Watchdog: B never arrives
    push(16'h4000, 32'h44444444, 4'hF);
    tick();
    awready = 1'b1;
    wready  = 1'b1;
    n = 0;
    while (!timeout && n < 400) begin
      tick();
      n++;
      awready = 1'b0;
      wready  = 1'b0;
    end
    if (n >= 400) fail_bound("tmo.wait");
    chk("tmo.cycles", 32'(n), 32'd256);
    chk("tmo.bready", 32'(bready), 32'd0);
    chk("tmo.awvalid", 32'(awvalid), 32'd0);
    chk("tmo.busy", 32'(busy), 32'd0);
    chk("tmo.wr_count", 32'(wr_count), 32'd17);
    push(16'h4004, 32'h55555555, 4'hA);
    v = '{16'h4004, 32'h55555555, 4'hA, 0, 0, 0, OKAY, 1'b0, 1'b0, 1'b0, 16'd18};
    serve(v, "tmo.next");
    chk("tmo.sticky", 32'(timeout), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("tmo.cleared", 32'(timeout), 32'd0);
`else
    // Without the watchdog a long stall just waits
    push(16'h4000, 32'h44444444, 4'hF);
    n = 0;
    repeat (300) begin
      tick();
      n++;
    end
    chk("stall.timeout", 32'(timeout), 32'd0);
    chk("stall.awvalid", 32'(awvalid), 32'd1);
    v = '{16'h4000, 32'h44444444, 4'hF, 0, 0, 0, OKAY, 1'b0, 1'b0, 1'b0, 16'd18};
    serve(v, "stall.done");
`endif

    // Reset in WAIT_B with three commands queued
    awready = 1'b1;
    wready  = 1'b1;
    for (int i = 0; i < 4; i++) push(16'h5000 + 16'(4 * i), 32'h5000 + 32'(i), 4'hF);
    awready = 1'b0;
    wready  = 1'b0;
    n = 0;
    while (!bready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) fail_bound("arst.wait_b");
    chk("arst.busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst.awvalid", 32'(awvalid), 32'd0);
    chk("arst.wvalid", 32'(wvalid), 32'd0);
    chk("arst.bready", 32'(bready), 32'd0);
    chk("arst.busy", 32'(busy), 32'd0);
    chk("arst.wr_count", 32'(wr_count), 32'd0);
    chk("arst.awaddr", 32'(awaddr), 32'd0);
    chk("arst.wdata", wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("arst.cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (3) tick();
    chk("arst.idle_busy", 32'(busy), 32'd0);
    chk("arst.idle_awvalid", 32'(awvalid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
